// File: rtl/qarma_tweak_schedule.sv
// qarma_tweak_schedule
//
// Generates the QARMA round-tweak sequence from a 128-bit seed tweak.
// A sequence emits NUM_ROUNDS+1 tweaks: the seed (round 0), then one updated
// tweak per accepted output beat. The forward update is a cell permutation
// (phi) followed by the omega LFSR on cells 0..7 and 16..23. The inverse
// update undoes that: inverse omega on the same cells, then phi^-1.
//
// Cell numbering: cell 0 = bits 127:124, cell 31 = bits 3:0.
//
// Optional feature (compile-time macro QARMA_TWEAK_SCHED_ABORT_EN):
//   adds input 'abort'. Abort in RUN returns to IDLE at the next edge.
//   Abort in IDLE has no effect. Without the macro there is no abort port,
//   and a sequence ends only by completion or reset.
//
// Ports:
//   clk        in   1    clock, rising edge
//   rst        in   1    synchronous active-high reset
//   abort      in   1    (macro only) abandon the running sequence
//   in_valid   in   1    seed tweak offered
//   in_ready   out  1    high in IDLE only
//   in_tweak   in   128  seed tweak
//   in_inv     in   1    0 = forward schedule, 1 = inverse schedule
//   out_valid  out  1    high in RUN only
//   out_ready  in   1    consumer accepts the current tweak
//   out_tweak  out  128  current round tweak, straight from the register
//   out_round  out  5    round index of out_tweak (0 = seed)
//   out_last   out  1    out_round == NUM_ROUNDS

module qarma_tweak_schedule #(
    parameter int unsigned NUM_ROUNDS = 13
) (
    input  logic         clk,
    input  logic         rst,
`ifdef QARMA_TWEAK_SCHED_ABORT_EN
    input  logic         abort,
`endif
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_tweak,
    input  logic         in_inv,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_tweak,
    output logic [4:0]   out_round,
    output logic         out_last
);

    localparam logic [4:0] LastRound = 5'(NUM_ROUNDS);

    // Forward permutation: out cell i = in cell PHI[i].
    localparam logic [4:0] PHI [32] = '{
        5'd1,  5'd10, 5'd14, 5'd22, 5'd18, 5'd25, 5'd29, 5'd21,
        5'd0,  5'd8,  5'd12, 5'd4,  5'd19, 5'd27, 5'd31, 5'd23,
        5'd17, 5'd26, 5'd30, 5'd6,  5'd2,  5'd9,  5'd13, 5'd5,
        5'd16, 5'd24, 5'd28, 5'd20, 5'd3,  5'd11, 5'd15, 5'd7
    };

    // Inverse permutation: out cell i = in cell INV_PHI[i].
    localparam logic [4:0] INV_PHI [32] = '{
        5'd8,  5'd0,  5'd20, 5'd28, 5'd11, 5'd23, 5'd19, 5'd31,
        5'd9,  5'd21, 5'd1,  5'd29, 5'd10, 5'd22, 5'd2,  5'd30,
        5'd24, 5'd16, 5'd4,  5'd12, 5'd27, 5'd7,  5'd3,  5'd15,
        5'd25, 5'd5,  5'd17, 5'd13, 5'd26, 5'd6,  5'd18, 5'd14
    };

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } state_e;

    // ------------------------------------------------------------------
    // Cell-level helpers
    // ------------------------------------------------------------------

    // omega: b3b2b1b0 -> (b0^b1, b3, b2, b1)
    function automatic logic [3:0] omega(input logic [3:0] b);
        return {b[0] ^ b[1], b[3], b[2], b[1]};
    endfunction

    // omega^-1: b3b2b1b0 -> (b2, b1, b0, b3^b0)
    function automatic logic [3:0] omega_inv(input logic [3:0] b);
        return {b[2], b[1], b[0], b[3] ^ b[0]};
    endfunction

    // Cells 0..7 and 16..23 carry the LFSR; bit 3 of the cell index is clear.
    function automatic logic lfsr_cell(input int idx);
        return (idx % 16) < 8;
    endfunction

    function automatic logic [3:0] get_cell(input logic [127:0] x, input int idx);
        return x[127 - 4 * idx -: 4];
    endfunction

    // ------------------------------------------------------------------
    // Step functions (pure combinational)
    // ------------------------------------------------------------------

    function automatic logic [127:0] step_fwd(input logic [127:0] x);
        logic [127:0] y;
        logic [3:0]   c;
        y = '0;
        for (int i = 0; i < 32; i++) begin
            c = get_cell(x, int'(PHI[i]));
            if (lfsr_cell(i)) begin
                c = omega(c);
            end
            y[127 - 4 * i -: 4] = c;
        end
        return y;
    endfunction

    function automatic logic [127:0] step_inv(input logic [127:0] x);
        logic [127:0] m;
        logic [127:0] y;
        logic [3:0]   c;
        m = '0;
        y = '0;
        // Undo omega first, on the cells as they sit after the forward permutation.
        for (int i = 0; i < 32; i++) begin
            c = get_cell(x, i);
            if (lfsr_cell(i)) begin
                c = omega_inv(c);
            end
            m[127 - 4 * i -: 4] = c;
        end
        for (int i = 0; i < 32; i++) begin
            y[127 - 4 * i -: 4] = get_cell(m, int'(INV_PHI[i]));
        end
        return y;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------

    state_e       state_q, state_d;
    logic [127:0] tweak_q, tweak_d;
    logic [4:0]   round_q, round_d;
    logic         inv_q,   inv_d;

    logic [127:0] tweak_step;
    logic         last;
    logic         kill;

    assign tweak_step = inv_q ? step_inv(tweak_q) : step_fwd(tweak_q);
    assign last       = (round_q == LastRound);

`ifdef QARMA_TWEAK_SCHED_ABORT_EN
    assign kill = abort;
`else
    assign kill = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        tweak_d   = tweak_q;
        round_d   = round_q;
        inv_d     = inv_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    tweak_d = in_tweak;
                    inv_d   = in_inv;
                    round_d = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                out_valid = 1'b1;
                if (kill) begin
                    // Abort wins over a same-cycle handshake; registers freeze.
                    state_d = StIdle;
                end else if (out_ready) begin
                    if (last) begin
                        state_d = StIdle;
                    end else begin
                        tweak_d = tweak_step;
                        round_d = round_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            tweak_q <= '0;
            round_q <= '0;
            inv_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tweak_q <= tweak_d;
            round_q <= round_d;
            inv_q   <= inv_d;
        end
    end

    assign out_tweak = tweak_q;
    assign out_round = round_q;
    assign out_last  = last;

endmodule

// File: tb/tb_qarma_tweak_schedule.sv
// tb_qarma_tweak_schedule
//
// Directed bench for qarma_tweak_schedule. Each sequence's expected tweaks
// are computed by a cell-array model and pushed to a scoreboard queue when
// the seed is driven; they are popped and compared as output beats are
// accepted. Inputs are driven and outputs sampled on the falling clock edge.

module tb_qarma_tweak_schedule;

    localparam int NR = 13;

    localparam int PHI [32] = '{
        1, 10, 14, 22, 18, 25, 29, 21, 0, 8, 12, 4, 19, 27, 31, 23,
        17, 26, 30, 6, 2, 9, 13, 5, 16, 24, 28, 20, 3, 11, 15, 7
    };
    localparam int INV_PHI [32] = '{
        8, 0, 20, 28, 11, 23, 19, 31, 9, 21, 1, 29, 10, 22, 2, 30,
        24, 16, 4, 12, 27, 7, 3, 15, 25, 5, 17, 13, 26, 6, 18, 14
    };

    typedef struct packed {
        logic [127:0] t;
        logic [4:0]   r;
        logic         l;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_tweak;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_tweak;
    logic [4:0]   out_round;
    logic         out_last;
`ifdef QARMA_TWEAK_SCHED_ABORT_EN
    logic         abort;
`endif

    int   checks;
    int   failures;
    exp_t sb [$];

    qarma_tweak_schedule #(
        .NUM_ROUNDS(NR)
    ) dut (
        .clk      (clk),
        .rst      (rst),
`ifdef QARMA_TWEAK_SCHED_ABORT_EN
        .abort    (abort),
`endif
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_tweak (in_tweak),
        .in_inv   (in_inv),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_tweak(out_tweak),
        .out_round(out_round),
        .out_last (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- model ----------------
    function automatic logic [127:0] m_step(input logic [127:0] x, input logic inv);
        logic [3:0] c [32];
        logic [3:0] p [32];
        logic [3:0] b;
        logic [127:0] y;
        for (int i = 0; i < 32; i++) c[i] = x[127 - 4 * i -: 4];
        if (!inv) begin
            for (int i = 0; i < 32; i++) begin
                b = c[PHI[i]];
                if ((i % 16) < 8) b = {b[0] ^ b[1], b[3], b[2], b[1]};
                p[i] = b;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                b = c[i];
                if ((i % 16) < 8) c[i] = {b[2], b[1], b[0], b[3] ^ b[0]};
            end
            for (int i = 0; i < 32; i++) p[i] = c[INV_PHI[i]];
        end
        y = '0;
        for (int i = 0; i < 32; i++) y[127 - 4 * i -: 4] = p[i];
        return y;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one sequence. stall_at: round at which out_ready is held low for 5
    // cycles (-1 = none). kill_at: round at which rst (or abort) is pulsed.
    task automatic run_seq(input logic [127:0] seed, input logic inv, input int stall_at,
                           input int kill_at, input bit kill_by_abort,
                           output logic [127:0] r1, output logic [127:0] fin);
        logic [127:0] t;
        exp_t         e;
        int           budget;
        bit           stalled;
        t = seed;
        sb.delete();
        for (int r = 0; r <= NR; r++) begin
            sb.push_back('{t: t, r: 5'(r), l: (r == NR)});
            t = m_step(t, inv);
        end
        r1      = '0;
        fin     = '0;
        stalled = 1'b0;
        @(negedge clk);
        in_valid  = 1'b1;
        in_tweak  = seed;
        in_inv    = inv;
        out_ready = 1'b0;
        check("load_in_ready", 128'(in_ready), 128'd1);
        @(negedge clk);
        in_valid = 1'b0;
        budget   = 0;
        while (sb.size() > 0 && budget < 200) begin
            budget++;
            e = sb[0];
            if (int'(e.r) == kill_at) begin
                out_ready = 1'b1;
                in_valid  = 1'b1;
                if (kill_by_abort) begin
`ifdef QARMA_TWEAK_SCHED_ABORT_EN
                    abort    = 1'b1;
                    in_valid = 1'b0;
`endif
                end else begin
                    rst = 1'b1;
                end
                @(negedge clk);
                rst      = 1'b0;
                in_valid = 1'b0;
`ifdef QARMA_TWEAK_SCHED_ABORT_EN
                abort = 1'b0;
`endif
                check("kill_out_valid", 128'(out_valid), 128'd0);
                check("kill_in_ready", 128'(in_ready), 128'd1);
                if (!kill_by_abort) begin
                    check("rst_out_tweak", out_tweak, 128'd0);
                    check("rst_out_round", 128'(out_round), 128'd0);
                    check("rst_out_last", 128'(out_last), 128'd0);
                end
                @(negedge clk);
                check("kill_no_more_valid", 128'(out_valid), 128'd0);
                out_ready = 1'b0;
                sb.delete();
                return;
            end
            if (int'(e.r) == stall_at && !stalled) begin
                stalled   = 1'b1;
                out_ready = 1'b0;
                in_valid  = 1'b1;
                in_tweak  = ~seed;
                repeat (5) begin
                    @(negedge clk);
                    check("stall_tweak", out_tweak, e.t);
                    check("stall_round", 128'(out_round), 128'(e.r));
                    check("stall_valid", 128'(out_valid), 128'd1);
                    check("stall_in_ready", 128'(in_ready), 128'd0);
                end
                in_valid = 1'b0;
                continue;
            end
            out_ready = 1'b1;
            if (out_valid) begin
                void'(sb.pop_front());
                check("sb_tweak", out_tweak, e.t);
                check("sb_round", 128'(out_round), 128'(e.r));
                check("sb_last", 128'(out_last), 128'(e.l));
                if (e.r == 5'd1) r1 = out_tweak;
                if (e.l) fin = out_tweak;
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("seq_complete_in_budget", 128'(sb.size() == 0), 128'd1);
        check("end_out_valid", 128'(out_valid), 128'd0);
        check("end_in_ready", 128'(in_ready), 128'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [127:0] r1;
        logic [127:0] fin;
        logic [127:0] fin2;
        logic [127:0] seed;

        checks    = 0;
        failures  = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_tweak  = '0;
        in_inv    = 1'b0;
        out_ready = 1'b0;
`ifdef QARMA_TWEAK_SCHED_ABORT_EN
        abort = 1'b0;
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_in_ready", 128'(in_ready), 128'd1);
        check("reset_out_valid", 128'(out_valid), 128'd0);
        check("reset_out_tweak", out_tweak, 128'd0);
        check("reset_out_round", 128'(out_round), 128'd0);
        check("reset_out_last", 128'(out_last), 128'd0);

        // All-zero seed stays zero through every round.
        run_seq(128'd0, 1'b0, -1, -1, 1'b0, r1, fin);
        check("zero_final", fin, 128'd0);

        // Cell 1 = 2 lands on cell 0 and goes through omega.
        run_seq(128'h02000000_00000000_00000000_00000000, 1'b0, -1, -1, 1'b0, r1, fin);
        check("cell1_fwd_r1", r1, 128'h90000000_00000000_00000000_00000000);

        // Cell 0 = 1 lands on cell 8, untouched by omega.
        run_seq(128'h10000000_00000000_00000000_00000000, 1'b0, -1, -1, 1'b0, r1, fin);
        check("cell0_fwd_r1", r1, 128'h00000000_10000000_00000000_00000000);

        // Inverse undoes the cell-1 example.
        run_seq(128'h90000000_00000000_00000000_00000000, 1'b1, -1, -1, 1'b0, r1, fin);
        check("inv_r1", r1, 128'h02000000_00000000_00000000_00000000);

        // Forward then inverse returns the seed.
        for (int k = 0; k < 3; k++) begin
            seed = {$urandom(), $urandom(), $urandom(), $urandom()};
            run_seq(seed, 1'b0, -1, -1, 1'b0, r1, fin);
            run_seq(fin, 1'b1, -1, -1, 1'b0, r1, fin2);
            check("round_trip", fin2, seed);
        end

        // Back-pressure at round 4, pending seed during RUN.
        seed = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_seq(seed, 1'b0, 4, -1, 1'b0, r1, fin);

        // Reset at round 7, then a clean sequence afterwards.
        seed = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_seq(seed, 1'b0, -1, 7, 1'b0, r1, fin);
        run_seq(seed, 1'b1, -1, -1, 1'b0, r1, fin);

`ifdef QARMA_TWEAK_SCHED_ABORT_EN
        seed = {$urandom(), $urandom(), $urandom(), $urandom()};
        run_seq(seed, 1'b0, -1, 3, 1'b1, r1, fin);
        run_seq(seed, 1'b0, -1, -1, 1'b0, r1, fin);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
